// File: rtl/decoder_pkg.sv
// Shared opcode, FSM state and write-position encodings for the instruction decoder.
package decoder_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LI  = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_BR  = 4'd11;
  localparam logic [3:0] OP_NOP = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_REGREAD = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_t;

  localparam logic [1:0] WPOS_FULL = 2'd0;
  localparam logic [1:0] WPOS_LOW  = 2'd1;
  localparam logic [1:0] WPOS_HIGH = 2'd2;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode classifier: which FSM phases an instruction needs.
// Zero latency, no flow control; opcodes 12-14 are flagged illegal.
module opcode_classify
  import decoder_pkg::*;
(
  input  logic [3:0] op,
  output logic       needsRead,
  output logic       needsExec,
  output logic       writesBack,
  output logic       isImm,
  output logic       isIllegal
);

  always_comb begin
    needsRead  = 1'b0;
    needsExec  = 1'b0;
    writesBack = 1'b0;
    isImm      = 1'b0;
    isIllegal  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_MOV: begin
        needsRead  = 1'b1;
        needsExec  = 1'b1;
        writesBack = 1'b1;
      end
      OP_LI: begin
        isImm      = 1'b1;
        writesBack = 1'b1;
      end
      OP_CMP, OP_BR: begin
        needsRead = 1'b1;
        needsExec = 1'b1;
      end
      OP_NOP: ;
      default: isIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decoder.sv
// Sequences the register file through read/exec/writeback; one instruction in flight, ready only in IDLE.
// Latency accept->write: LI 2, ALU 4+. ILLEGAL_TRAP_EN: faults park in TRAP until reset.
module instr_decoder
  import decoder_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int REG_SEL_WIDTH = 3,
  parameter int EXEC_TIMEOUT  = 255
) (
  input  logic                     I_clk,
  input  logic                     I_reset_n,
  input  logic [DATA_WIDTH-1:0]    I_instr,
  input  logic                     I_instr_valid,
  output logic                     O_instr_ready,
  output logic                     O_regfile_enable,
  output logic [REG_SEL_WIDTH-1:0] O_rA_select,
  output logic [REG_SEL_WIDTH-1:0] O_rB_select,
  output logic [REG_SEL_WIDTH-1:0] O_rD_select,
  output logic                     O_rD_write,
  output logic [1:0]               O_rD_write_pos,
  output logic [DATA_WIDTH-1:0]    O_rD_in,
  output logic [3:0]               O_alu_op,
  output logic                     O_alu_start,
  input  logic                     I_alu_done,
  input  logic [DATA_WIDTH-1:0]    I_alu_result,
  output logic                     O_illegal
);

  localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ERR_STATE = ST_TRAP;
`else
  localparam state_t ERR_STATE = ST_IDLE;
`endif

  state_t                  state;
  state_t                  stateNext;
  logic [DATA_WIDTH-1:0]   instrQ;
  logic [DATA_WIDTH-1:0]   resultQ;
  logic [CNT_W-1:0]        execCnt;
  logic [3:0]              op;
  logic [REG_SEL_WIDTH-1:0] rD, rA, rB;
  logic                    hi;
  logic [7:0]              imm8;
  logic                    needsRead, needsExec, writesBack, isImm, isIllegal;
  logic                    timeout;
  logic                    operandPhase;

  assign op   = instrQ[15:12];
  assign rD   = instrQ[11:9];
  assign hi   = instrQ[8];
  assign rA   = instrQ[7:5];
  assign rB   = instrQ[4:2];
  assign imm8 = instrQ[7:0];

  opcode_classify u_classify (
    .op         (op),
    .needsRead  (needsRead),
    .needsExec  (needsExec),
    .writesBack (writesBack),
    .isImm      (isImm),
    .isIllegal  (isIllegal)
  );

  // A done arriving in the very cycle the count expires still wins over the timeout.
  assign timeout = (state == ST_EXEC) && !I_alu_done && (execCnt == CNT_W'(EXEC_TIMEOUT));
  assign operandPhase = (state == ST_REGREAD) || (state == ST_EXEC) || (state == ST_WB);

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) state <= ST_IDLE;
    else            state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:    if (I_instr_valid) stateNext = ST_DECODE;
      ST_DECODE: begin
        if (isIllegal)      stateNext = ERR_STATE;
        else if (isImm)     stateNext = ST_WB;
        else if (needsExec) stateNext = ST_REGREAD;
        else                stateNext = ST_IDLE;
      end
      ST_REGREAD: stateNext = ST_EXEC;
      ST_EXEC: begin
        if (I_alu_done)   stateNext = writesBack ? ST_WB : ST_IDLE;
        else if (timeout) stateNext = ERR_STATE;
      end
      ST_WB:      stateNext = ST_IDLE;
      ST_TRAP:    stateNext = ERR_STATE;
      default:    stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      instrQ  <= '0;
      resultQ <= '0;
      execCnt <= '0;
    end else begin
      if (state == ST_IDLE && I_instr_valid) instrQ <= I_instr;
      if (state == ST_EXEC && I_alu_done)    resultQ <= I_alu_result;
      execCnt <= (state == ST_EXEC) ? execCnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    O_instr_ready    = (state == ST_IDLE);
    O_regfile_enable = (state == ST_REGREAD) || (state == ST_WB);
    O_rA_select      = '0;
    O_rB_select      = '0;
    O_rD_select      = '0;
    O_rD_write       = 1'b0;
    O_rD_write_pos   = WPOS_FULL;
    O_rD_in          = '0;
    O_alu_op         = '0;
    O_alu_start      = (state == ST_EXEC) && (execCnt == '0);
    O_illegal        = ((state == ST_DECODE) && isIllegal) || timeout;
`ifdef ILLEGAL_TRAP_EN
    if (state == ST_TRAP) O_illegal = 1'b1;
`endif
    if (operandPhase && needsRead) begin
      O_rA_select = rA;
      O_rB_select = rB;
    end
    if (operandPhase && needsExec) O_alu_op = op;
    if (state == ST_WB) begin
      O_rD_select = rD;
      O_rD_write  = 1'b1;
      if (isImm) begin
        O_rD_write_pos = hi ? WPOS_HIGH : WPOS_LOW;
        O_rD_in        = {imm8, imm8};
      end else begin
        O_rD_in = resultQ;
      end
    end
  end

endmodule

// File: tb/tb_instr_decoder.sv
// Scenario bench for instr_decoder with a writeback scoreboard; EXEC_TIMEOUT shortened to 4.
module tb_instr_decoder;

  logic        clk = 1'b0;
  logic        resetN;
  logic [15:0] instr;
  logic        instrValid;
  logic        instrReady;
  logic        regfileEnable;
  logic [2:0]  rASelect, rBSelect, rDSelect;
  logic        rDWrite;
  logic [1:0]  rDWritePos;
  logic [15:0] rDIn;
  logic [3:0]  aluOp;
  logic        aluStart;
  logic        aluDone;
  logic [15:0] aluResult;
  logic        illegal;

  instr_decoder #(.EXEC_TIMEOUT(4)) dut (
    .I_clk            (clk),
    .I_reset_n        (resetN),
    .I_instr          (instr),
    .I_instr_valid    (instrValid),
    .O_instr_ready    (instrReady),
    .O_regfile_enable (regfileEnable),
    .O_rA_select      (rASelect),
    .O_rB_select      (rBSelect),
    .O_rD_select      (rDSelect),
    .O_rD_write       (rDWrite),
    .O_rD_write_pos   (rDWritePos),
    .O_rD_in          (rDIn),
    .O_alu_op         (aluOp),
    .O_alu_start      (aluStart),
    .I_alu_done       (aluDone),
    .I_alu_result     (aluResult),
    .O_illegal        (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  rd;
    logic [1:0]  pos;
    logic [15:0] data;
  } wbExp_t;

  wbExp_t expQ[$];
  wbExp_t monExp;
  int nCompared = 0;
  int nMismatch = 0;

  // Every write strobe must match the oldest expected writeback; stray strobes fail.
  always @(negedge clk) begin
    if (resetN === 1'b1 && rDWrite === 1'b1) begin
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatch++;
        $display("FAIL wb_unexpected: got rd=%0d pos=%0d data=%h, required no write strobe", rDSelect, rDWritePos, rDIn);
      end else begin
        monExp = expQ.pop_front();
        if ({rDSelect, rDWritePos, rDIn} !== monExp) begin
          nMismatch++;
          $display("FAIL wb_data: got rd=%0d pos=%0d data=%h, required rd=%0d pos=%0d data=%h",
                   rDSelect, rDWritePos, rDIn, monExp.rd, monExp.pos, monExp.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called just after a negedge; holds valid until the accept edge.
  task automatic sendInstr(input logic [15:0] w);
    int waitCnt;
    waitCnt = 0;
    while (instrReady !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (instrReady !== 1'b1) begin
      nCompared++;
      nMismatch++;
      $display("FAIL ready_wait: ready=%b after %0d cycles, required 1", instrReady, waitCnt);
    end
    instr      = w;
    instrValid = 1'b1;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    instr      = '0;
  endtask

  task automatic test_reset;
    resetN = 1'b0; instrValid = 1'b0; instr = '0; aluDone = 1'b0; aluResult = '0;
    repeat (2) @(negedge clk);
    nCompared++;
    if (instrReady !== 1'b1) begin nMismatch++; $display("FAIL reset_ready: got %b, required 1", instrReady); end
    nCompared++;
    if ({regfileEnable, rDWrite, aluStart, illegal} !== 4'b0000) begin
      nMismatch++; $display("FAIL reset_ctrl: en/wr/start/ill=%b, required 0000", {regfileEnable, rDWrite, aluStart, illegal});
    end
    nCompared++;
    if ({rASelect, rBSelect, rDSelect, rDWritePos, rDIn, aluOp} !== 31'd0) begin
      nMismatch++; $display("FAIL reset_data: got %h, required 0", {rASelect, rBSelect, rDSelect, rDWritePos, rDIn, aluOp});
    end
    resetN = 1'b1;
  endtask

  task automatic test_li;
    @(negedge clk);
    expQ.push_back({3'd1, 2'd2, 16'h1212});
    sendInstr(16'h8312);
    @(negedge clk);
    nCompared++;
    if (rDWrite !== 1'b0) begin nMismatch++; $display("FAIL li_early: write=%b in cycle 1, required 0", rDWrite); end
    @(negedge clk);
    nCompared++;
    if (rDWrite !== 1'b1) begin nMismatch++; $display("FAIL li_latency: write=%b in cycle 2, required 1", rDWrite); end
    @(negedge clk);
    nCompared++;
    if (instrReady !== 1'b1) begin nMismatch++; $display("FAIL li_b2b_ready: got %b, required 1", instrReady); end
    expQ.push_back({3'd2, 2'd1, 16'h5A5A});
    sendInstr(16'h845A);
    repeat (2) @(negedge clk);
    nCompared++;
    if (rDWrite !== 1'b1) begin nMismatch++; $display("FAIL li_low_latency: write=%b, required 1", rDWrite); end
  endtask

  task automatic test_alu;
    @(negedge clk);
    expQ.push_back({3'd5, 2'd0, 16'hBEEF});
    sendInstr(16'h0A28);
    @(negedge clk);
    nCompared++;
    if ({regfileEnable, aluStart} !== 2'b00) begin nMismatch++; $display("FAIL add_decode: en/start=%b, required 00", {regfileEnable, aluStart}); end
    @(negedge clk);
    nCompared++;
    if ({regfileEnable, rASelect, rBSelect} !== {1'b1, 3'd1, 3'd2}) begin
      nMismatch++; $display("FAIL add_regread: en=%b rA=%0d rB=%0d, required 1/1/2", regfileEnable, rASelect, rBSelect);
    end
    @(negedge clk);
    nCompared++;
    if ({aluStart, aluOp} !== {1'b1, 4'd0}) begin nMismatch++; $display("FAIL add_start: start=%b op=%0d, required 1/0", aluStart, aluOp); end
    @(negedge clk);
    nCompared++;
    if ({aluStart, rASelect, rBSelect} !== {1'b0, 3'd1, 3'd2}) begin
      nMismatch++; $display("FAIL add_exec2: start=%b rA=%0d rB=%0d, required 0/1/2", aluStart, rASelect, rBSelect);
    end
    aluDone = 1'b1; aluResult = 16'hBEEF;
    @(negedge clk);
    aluDone = 1'b0; aluResult = '0;
    nCompared++;
    if ({rDWrite, regfileEnable} !== 2'b11) begin nMismatch++; $display("FAIL add_wb: wr/en=%b, required 11", {rDWrite, regfileEnable}); end
    @(negedge clk);
    nCompared++;
    if (instrReady !== 1'b1) begin nMismatch++; $display("FAIL add_ready: got %b, required 1", instrReady); end
    expQ.push_back({3'd3, 2'd0, 16'h1234});
    sendInstr(16'h169C);
    repeat (2) @(negedge clk);
    nCompared++;
    if ({rASelect, rBSelect} !== {3'd4, 3'd7}) begin nMismatch++; $display("FAIL sub_sel: rA=%0d rB=%0d, required 4/7", rASelect, rBSelect); end
    @(negedge clk);
    nCompared++;
    if (aluOp !== 4'd1) begin nMismatch++; $display("FAIL sub_op: got %0d, required 1", aluOp); end
    aluDone = 1'b1; aluResult = 16'h1234;
    @(negedge clk);
    aluDone = 1'b0; aluResult = '0;
    nCompared++;
    if (rDWrite !== 1'b1) begin nMismatch++; $display("FAIL sub_latency4: write=%b, required 1", rDWrite); end
  endtask

  task automatic test_no_wb;
    @(negedge clk);
    sendInstr(16'hA000);
    repeat (3) @(negedge clk);
    nCompared++;
    if (aluStart !== 1'b1) begin nMismatch++; $display("FAIL cmp_start: got %b, required 1", aluStart); end
    aluDone = 1'b1;
    @(negedge clk);
    aluDone = 1'b0;
    nCompared++;
    if ({instrReady, rDWrite} !== 2'b10) begin nMismatch++; $display("FAIL cmp_done: ready/wr=%b, required 10", {instrReady, rDWrite}); end
    sendInstr(16'hF000);
    @(negedge clk);
    nCompared++;
    if ({instrReady, regfileEnable, aluStart, rDWrite} !== 4'b0000) begin
      nMismatch++; $display("FAIL nop_decode: ready/en/start/wr=%b, required 0000", {instrReady, regfileEnable, aluStart, rDWrite});
    end
    @(negedge clk);
    nCompared++;
    if ({instrReady, regfileEnable, aluStart} !== 3'b100) begin
      nMismatch++; $display("FAIL nop_return: ready/en/start=%b, required 100", {instrReady, regfileEnable, aluStart});
    end
  endtask

  task automatic test_reset_mid_exec;
    @(negedge clk);
    sendInstr(16'h0A28);
    repeat (3) @(negedge clk);
    nCompared++;
    if (aluStart !== 1'b1) begin nMismatch++; $display("FAIL rst_mid_exec_entry: start=%b, required 1", aluStart); end
    #2 resetN = 1'b0;
    #1;
    nCompared++;
    if ({instrReady, rDWrite, regfileEnable, aluStart} !== 4'b1000) begin
      nMismatch++; $display("FAIL rst_mid_async: ready/wr/en/start=%b, required 1000", {instrReady, rDWrite, regfileEnable, aluStart});
    end
    @(negedge clk);
    resetN = 1'b1;
    aluDone = 1'b1; aluResult = 16'hDEAD;
    @(negedge clk);
    aluDone = 1'b0; aluResult = '0;
    nCompared++;
    if ({instrReady, rDWrite} !== 2'b10) begin nMismatch++; $display("FAIL rst_mid_after: ready/wr=%b, required 10", {instrReady, rDWrite}); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout;
    @(negedge clk);
    sendInstr(16'h0000);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nCompared++;
      if (illegal !== 1'b0) begin nMismatch++; $display("FAIL tmo_early: illegal=%b in exec cycle %0d, required 0", illegal, k); end
    end
    @(negedge clk);
    nCompared++;
    if ({illegal, rDWrite} !== 2'b10) begin nMismatch++; $display("FAIL tmo_fire: ill/wr=%b, required 10", {illegal, rDWrite}); end
    @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
    nCompared++;
    if ({illegal, instrReady} !== 2'b10) begin nMismatch++; $display("FAIL tmo_trap: ill/ready=%b, required 10", {illegal, instrReady}); end
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
`else
    nCompared++;
    if ({illegal, instrReady} !== 2'b01) begin nMismatch++; $display("FAIL tmo_pulse: ill/ready=%b, required 01", {illegal, instrReady}); end
`endif
    aluDone = 1'b1; aluResult = 16'h5555;
    @(negedge clk);
    aluDone = 1'b0; aluResult = '0;
    repeat (3) @(negedge clk);
    nCompared++;
    if ({illegal, instrReady, aluStart} !== 3'b010) begin
      nMismatch++; $display("FAIL tmo_stray_done: ill/ready/start=%b, required 010", {illegal, instrReady, aluStart});
    end
  endtask

  task automatic test_illegal;
    @(negedge clk);
    sendInstr(16'hC000);
    @(negedge clk);
    nCompared++;
    if ({illegal, instrReady, regfileEnable} !== 3'b100) begin
      nMismatch++; $display("FAIL ill_decode: ill/ready/en=%b, required 100", {illegal, instrReady, regfileEnable});
    end
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nCompared++;
      if ({illegal, instrReady} !== 2'b10) begin nMismatch++; $display("FAIL ill_trap_hold: ill/ready=%b cycle %0d, required 10", {illegal, instrReady}, k); end
    end
    resetN = 1'b0;
    #1;
    nCompared++;
    if ({illegal, instrReady} !== 2'b01) begin nMismatch++; $display("FAIL ill_trap_reset: ill/ready=%b, required 01", {illegal, instrReady}); end
    @(negedge clk);
    resetN = 1'b1;
`else
    @(negedge clk);
    nCompared++;
    if ({illegal, instrReady} !== 2'b01) begin nMismatch++; $display("FAIL ill_pulse: ill/ready=%b, required 01", {illegal, instrReady}); end
`endif
  endtask

  initial begin
    test_reset();
    test_li();
    test_alu();
    test_no_wb();
    test_reset_mid_exec();
    test_timeout();
    test_illegal();
    repeat (3) @(negedge clk);
    nCompared++;
    if (expQ.size() != 0) begin nMismatch++; $display("FAIL wb_missing: %0d writebacks outstanding, required 0", expQ.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
